// File: rtl/request_unit_pkg.sv
// Shared types for the request sequencer: data word and request-state encoding.
// Imported by the interface and the sequencer.
package request_unit_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        MEM    = 2'd2,
        HALTED = 2'd3
    } reqstate_t;

    // Reference only: the PC register itself lives in the datapath.
    localparam word_t PC_RESET = 32'h0000_0000;

endpackage

// File: rtl/request_unit_if.sv
// Signal bundle between the request sequencer and its neighbours
// (instruction/data memory ports, control_unit decode, commit strobes).
interface request_unit_if;
    import request_unit_pkg::*;

    word_t iload;
    logic  ihit;
    logic  dhit;
    logic  cu_dREN;
    logic  cu_dWEN;
    logic  cu_halt;
    word_t instruction;
    logic  imemREN;
    logic  dmemREN;
    logic  dmemWEN;
    logic  pc_en;
    logic  reg_commit;
    logic  halt;
    logic  err;
    word_t retired;

    modport ru (
        input  iload, ihit, dhit, cu_dREN, cu_dWEN, cu_halt,
        output instruction, imemREN, dmemREN, dmemWEN, pc_en, reg_commit,
               halt, err, retired
    );

    modport tb (
        output iload, ihit, dhit, cu_dREN, cu_dWEN, cu_halt,
        input  instruction, imemREN, dmemREN, dmemWEN, pc_en, reg_commit,
               halt, err, retired
    );

endinterface

// File: rtl/request_unit.sv
// Fetch/decode/memory request sequencer feeding control_unit and the caches;
// issues commit strobes, counts retired instructions, keeps sticky halt/err.
//
// state  | meaning
// FETCH  | imemREN held until ihit, word latched into instruction
// DECODE | cu_* valid; commit ALU op, go to MEM, or halt
// MEM    | dmemREN/dmemWEN held until dhit, commit on the hit cycle
// HALTED | idle until reset
module request_unit
    import request_unit_pkg::*;
#(
    parameter logic [15:0] MAX_WAIT = 16'd1024
) (
    input logic       CLK,
    input logic       RST,
    request_unit_if.ru ruif
);

    reqstate_t   state, next_state;
    word_t       instruction_q;
    word_t       retired_q;
    logic        halt_q;
    logic        err_q;
    logic [15:0] wait_q;
    logic [15:0] wait_inc;

    logic timeout_hit;
    logic load_instr;
    logic commit;
    logic set_halt;
    logic set_err;
    logic imem_ren;
    logic dmem_ren;
    logic dmem_wen;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= FETCH;
            instruction_q <= '0;
            retired_q     <= '0;
            halt_q        <= 1'b0;
            err_q         <= 1'b0;
            wait_q        <= '0;
        end else begin
            state <= next_state;
            if (load_instr)
                instruction_q <= ruif.iload;
            if (set_halt || set_err)
                halt_q <= 1'b1;
            if (set_err)
                err_q <= 1'b1;
            if (commit && (retired_q != '1))
                retired_q <= retired_q + 32'd1;
            // Counter only runs while a request is outstanding in the same state.
            if (next_state != state)
                wait_q <= '0;
            else if ((state == FETCH) || (state == MEM))
                wait_q <= wait_inc;
            else
                wait_q <= '0;
        end
    end

    assign wait_inc    = wait_q + 16'd1;
    assign timeout_hit = (MAX_WAIT != 16'd0) && (wait_inc == MAX_WAIT);

    always_comb begin
        next_state = state;
        load_instr = 1'b0;
        commit     = 1'b0;
        set_halt   = 1'b0;
        set_err    = 1'b0;
        imem_ren   = 1'b0;
        dmem_ren   = 1'b0;
        dmem_wen   = 1'b0;

        case (state)
            FETCH: begin
                imem_ren = 1'b1;
                if (ruif.ihit) begin
                    load_instr = 1'b1;
                    next_state = DECODE;
                end else if (timeout_hit) begin
                    set_err    = 1'b1;
                    next_state = HALTED;
                end
            end
            DECODE: begin
                // Halt takes priority over any memory request from the same word.
                if (ruif.cu_halt) begin
                    set_halt   = 1'b1;
                    next_state = HALTED;
                end else if (ruif.cu_dREN || ruif.cu_dWEN) begin
                    next_state = MEM;
                end else begin
                    commit     = 1'b1;
                    next_state = FETCH;
                end
            end
            MEM: begin
                dmem_ren = ruif.cu_dREN;
                dmem_wen = ruif.cu_dWEN;
                if (ruif.dhit) begin
                    commit     = 1'b1;
                    next_state = FETCH;
                end else if (timeout_hit) begin
                    set_err    = 1'b1;
                    next_state = HALTED;
                end
            end
            HALTED: begin
                next_state = HALTED;
            end
            default: begin
                next_state = FETCH;
            end
        endcase

        // Reset suppresses every request and strobe, including a same-cycle dhit.
        if (RST) begin
            next_state = FETCH;
            load_instr = 1'b0;
            commit     = 1'b0;
            set_halt   = 1'b0;
            set_err    = 1'b0;
            imem_ren   = 1'b0;
            dmem_ren   = 1'b0;
            dmem_wen   = 1'b0;
        end
    end

    assign ruif.instruction = instruction_q;
    assign ruif.imemREN     = imem_ren;
    assign ruif.dmemREN     = dmem_ren;
    assign ruif.dmemWEN     = dmem_wen;
    assign ruif.pc_en       = commit;
    assign ruif.reg_commit  = commit;
    assign ruif.halt        = halt_q;
    assign ruif.err         = err_q;
    assign ruif.retired     = retired_q;

endmodule
